// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/cacheline, L2 arbiter state and op encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } lc3b_arb_state;

  typedef struct packed {
    logic read;
    logic write;
  } l2_op_t;

  // Width of a saturating counter that must reach 'limit'; never narrower than 1 bit.
  function automatic int unsigned starve_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of L1 miss ports and the unified L2 port seen by l2_arbiter.
interface l2_arbiter_if;
  import lc3b_types::*;

  logic          i_read;
  lc3b_word      i_address;
  logic          i_resp;
  lc3b_cacheline i_rdata;

  logic          d_read;
  logic          d_write;
  lc3b_word      d_address;
  lc3b_cacheline d_wdata;
  logic          d_resp;
  lc3b_cacheline d_rdata;

  logic          l2_read;
  logic          l2_write;
  lc3b_word      l2_address;
  lc3b_cacheline l2_wdata;
  logic          l2_resp;
  lc3b_cacheline l2_rdata;

  logic          arb_conflict_inc;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_resp, l2_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata,
           arb_conflict_inc
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_resp, l2_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata,
           arb_conflict_inc
  );

endinterface

// File: rtl/l2_arbiter_req_latch.sv
// Holds the granted request's address, write line and op for the whole L2 transaction.
module l2_arbiter_req_latch
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  lc3b_word      address_in,
  input  lc3b_cacheline wdata_in,
  input  l2_op_t        op_in,
  output lc3b_word      address,
  output lc3b_cacheline wdata,
  output l2_op_t        op
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= '0;
      wdata   <= '0;
      op      <= '0;
    end else if (load) begin
      address <= address_in;
      wdata   <= wdata_in;
      op      <= op_in;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the unified L2 port between the I- and D-side L1 miss ports, one line at a time,
// with a saturating counter bounding how long a pending I request can be passed over.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic      clk,
  input logic      rst_n,
  l2_arbiter_if.slave bus
);

  localparam int unsigned       CW    = starve_width(STARVE_LIMIT);
  localparam logic [CW-1:0]     LIMIT = CW'(STARVE_LIMIT);

  lc3b_arb_state state, state_next;
  logic [CW-1:0] starve_cnt;

  logic          pend_i, pend_d;
  logic          grant_i, grant_d, serving;
  l2_op_t        op_in, op_q;
  lc3b_word      addr_in, addr_q;
  lc3b_cacheline wdata_in, wdata_q;

  // I wins a conflict only once D has been preferred STARVE_LIMIT times in a row.
  always_comb begin
    pend_i  = bus.i_read;
    pend_d  = bus.d_read | bus.d_write;
    grant_i = (state == IDLE) && pend_i && (!pend_d || (starve_cnt == LIMIT));
    grant_d = (state == IDLE) && pend_d && !grant_i;
  end

  always_comb begin
    if (grant_i) begin
      addr_in  = bus.i_address;
      wdata_in = '0;
      op_in    = '{read: 1'b1, write: 1'b0};
    end else begin
      addr_in  = bus.d_address;
      wdata_in = bus.d_wdata;
      op_in    = '{read: bus.d_read & ~bus.d_write, write: bus.d_write};
    end
  end

  l2_arbiter_req_latch u_req_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant_i | grant_d),
    .address_in (addr_in),
    .wdata_in   (wdata_in),
    .op_in      (op_in),
    .address    (addr_q),
    .wdata      (wdata_q),
    .op         (op_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I, SERVE_D: if (bus.l2_resp) state_next = TURN;
      TURN:             state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (grant_i)
      starve_cnt <= '0;
    else if (grant_d && pend_i && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    serving              = (state == SERVE_I) || (state == SERVE_D);
    bus.l2_read          = serving & op_q.read;
    bus.l2_write         = serving & op_q.write;
    bus.l2_address       = addr_q;
    bus.l2_wdata         = wdata_q;
    bus.i_resp           = (state == SERVE_I) & bus.l2_resp;
    bus.d_resp           = (state == SERVE_D) & bus.l2_resp;
    bus.i_rdata          = bus.l2_rdata;
    bus.d_rdata          = bus.l2_rdata;
    // Gated by rst_n so the perf pulse is quiet while requests are held through reset.
    bus.arb_conflict_inc = rst_n & (state == IDLE) & pend_i & pend_d;
  end

  a_no_dual_dreq: assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write));

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between both L1 miss ports and l2_cache.
- Grants one whole cacheline transaction at a time, latches its address and data, and routes the L2 response back to the granted requester.
- Bounds instruction-side starvation with a saturating counter and emits a perf pulse on every conflict.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive D grants made while I is pending before I is forced. 0 means I always wins a conflict.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  16 (lc3b_word)  I-cache line address
- i_resp  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  128 (lc3b_cacheline)  line returned to I-cache
- d_read, d_write  in  1 each  D-cache line read/write request, held until d_resp
- d_address  in  16  D-cache line address
- d_wdata  in  128  D-cache writeback line
- d_resp  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  128  line returned to D-cache
- l2_read, l2_write  out  1 each  request to L2
- l2_address  out  16  latched address to L2
- l2_wdata  out  128  latched write line to L2
- l2_resp  in  1  L2 completion pulse
- l2_rdata  in  128  L2 read line
- arb_conflict_inc  out  1  perf pulse: both requesters pending at a grant decision

Behaviour:
- State machine: IDLE, SERVE_I, SERVE_D, TURN.
- Reset (async, rst_n=0):
  - state=IDLE; starve_cnt=0; address/wdata/op latches=0.
  - All outputs 0: l2_read, l2_write, i_resp, d_resp, arb_conflict_inc. i_rdata and d_rdata are don't-care but must be driven.
  - Any in-flight transaction is discarded; l2_cache is reset by the same event.
- IDLE:
  - Evaluate pend_i=i_read and pend_d=d_read|d_write each cycle.
  - Only I pending: latch i_address and op=read, go to SERVE_I.
  - Only D pending: latch d_address, d_wdata and op, go to SERVE_D.
  - Both pending:
    - starve_cnt==STARVE_LIMIT: grant I.
    - Otherwise: grant D and increment starve_cnt, saturating at STARVE_LIMIT.
    - arb_conflict_inc=1 for that single cycle.
  - Any I grant clears starve_cnt. A D grant made without I pending leaves starve_cnt unchanged.
  - d_read and d_write both high is illegal. The write wins, and a simulation assertion fires.
- SERVE_x:
  - l2_read/l2_write are driven from the registered op, and l2_address/l2_wdata from the latches.
  - All four are stable for the whole state and do not track requester inputs.
  - Latency: request first seen in IDLE at cycle N gives l2_* asserted from cycle N+1.
- Response:
  - When l2_resp=1 in SERVE_x, x_resp=1 combinationally in the same cycle and x_rdata=l2_rdata (passthrough).
  - The non-granted resp is 0.
  - Next state is TURN.
- TURN:
  - Exactly one cycle; l2_read=l2_write=0.
  - All requests are ignored, because the L2 registers its request inputs by one cycle and must observe a deasserted request.
  - Requesters drop their request the cycle after resp.
  - Next state is IDLE.
- Spurious l2_resp in IDLE or TURN is ignored: no resp pulse, no state change.
- Throughput: back-to-back transactions are separated by ≥2 idle L2 cycles (TURN plus the IDLE decision).
- The starve_cnt width is $clog2(STARVE_LIMIT+1), minimum 1 bit.

Decomposition:
- lc3b_types (shared package) gets:
  - enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D, TURN}.
  - Existing lc3b_word and lc3b_cacheline are reused.
- One natural sub-module, l2_arbiter_req_latch: registers address, wdata and op on the grant strobe, with async active-low clear.
- The FSM and starvation counter stay in the top module.

Test Plan:
- I-only read, addr 0x1230; L2 responds 3 cycles later with line 0xA5..A5:
  - l2_read=1 with l2_address=0x1230 at N+1.
  - i_resp pulses one cycle with i_rdata=0xA5..A5; d_resp stays 0.
  - l2_read=0 in TURN.
- D-only write, addr 0x4440, wdata 0x0F..0F:
  - l2_write=1, l2_wdata=0x0F..0F, held stable even though d_address is changed to 0xFFFF mid-transaction.
  - d_resp pulses once.
- Simultaneous I (0x0100) and D read (0x2000), starve_cnt=0:
  - D granted first and arb_conflict_inc pulses.
  - After D's resp and TURN, I is granted and starve_cnt returns to 0.
- STARVE_LIMIT=2, I held and D re-requesting continuously:
  - Grant order D, D, I, D, D, I.
  - arb_conflict_inc pulses on every decision.
- rst_n=0 asserted mid SERVE_D, then released:
  - Outputs go to 0 immediately, without waiting for a clock edge, and state=IDLE.
  - A late l2_resp produces no d_resp.
  - A new I request is served normally.
- l2_resp pulsed in IDLE, and requests held during TURN:
  - The IDLE pulse produces no i_resp/d_resp.
  - No grant occurs in TURN; the grant happens in the following IDLE cycle.
